// File: rtl/spi_master.sv
// SPI bus initiator: sends one WIDTH-bit word per SS_n assertion and returns the word
// sampled from MISO over a valid/ready handshake.
module spi_master #(
  parameter int CPOL    = 0,
  parameter int CPHA    = 0,
  parameter int FSB     = 1,
  parameter int WIDTH   = 8,
  parameter int CLK_DIV = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             spi_sclk,
  output logic             spi_ss_n,
  output logic             spi_mosi,
  input  logic             spi_miso,
  input  logic             tx_valid,
  output logic             tx_ready,
  input  logic [WIDTH-1:0] tx_data,
  output logic             rx_valid,
  input  logic             rx_ready,
  output logic [WIDTH-1:0] rx_data,
  output logic             rx_overrun,
  output logic             busy
);

  localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam int EW = $clog2(2 * WIDTH + 1);
  localparam logic [EW-1:0] LAST_EDGE   = EW'(2 * WIDTH);
  localparam logic [EW-1:0] LAST_SAMPLE = (CPHA != 0) ? EW'(2 * WIDTH) : EW'(2 * WIDTH - 1);
  localparam logic SCLK_IDLE = (CPOL != 0);

  typedef enum logic [2:0] {IDLE, LEAD, XFER, TRAIL, GAP} state_t;

  state_t           state, state_nxt;
  logic [DW-1:0]    div_cnt;
  logic [EW-1:0]    edge_cnt;
  logic [EW-1:0]    edge_num;
  logic [WIDTH-1:0] tx_shift;
  logic [WIDTH-1:0] rx_shift;
  logic             tick, handshake, edge_fire, sample_now, shift_now, rx_done;

  function automatic logic first_bit(input logic [WIDTH-1:0] v);
    return (FSB != 0) ? v[WIDTH-1] : v[0];
  endfunction

  function automatic logic [WIDTH-1:0] shift_out(input logic [WIDTH-1:0] v);
    return (FSB != 0) ? {v[WIDTH-2:0], 1'b0} : {1'b0, v[WIDTH-1:1]};
  endfunction

  assign tick      = (div_cnt == DW'(CLK_DIV - 1));
  assign handshake = tx_valid && tx_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (handshake) state_nxt = LEAD;
      LEAD:    if (tick) state_nxt = XFER;
      XFER:    if (tick && edge_cnt == LAST_EDGE) state_nxt = TRAIL;
      TRAIL:   if (tick) state_nxt = GAP;
      GAP:     if (tick) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    tx_ready = 1'b0;
    busy     = 1'b1;
    spi_ss_n = 1'b0;
    case (state)
      IDLE: begin
        tx_ready = 1'b1;
        busy     = 1'b0;
        spi_ss_n = 1'b1;
      end
      GAP:     spi_ss_n = 1'b1;
      default: ;
    endcase
  end

  // edge_num is the SCLK edge about to be produced; the first one leaves LEAD,
  // and after edge 2*WIDTH XFER idles one more divider period before TRAIL.
  always_comb begin
    edge_num  = edge_cnt + EW'(1);
    edge_fire = 1'b0;
    if (state == LEAD && tick)
      edge_fire = 1'b1;
    else if (state == XFER && tick && edge_cnt != LAST_EDGE)
      edge_fire = 1'b1;
  end

  assign sample_now = edge_fire && ((CPHA != 0) ? !edge_num[0] : edge_num[0]);
  assign shift_now  = edge_fire && ((CPHA != 0) ? edge_num[0]
                                                 : (!edge_num[0] && edge_num != LAST_EDGE));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      div_cnt  <= '0;
      edge_cnt <= '0;
      spi_sclk <= SCLK_IDLE;
      spi_mosi <= 1'b0;
      tx_shift <= '0;
      rx_shift <= '0;
      rx_done  <= 1'b0;
    end else begin
      rx_done <= sample_now && (edge_num == LAST_SAMPLE);
      if (state == IDLE || tick) div_cnt <= '0;
      else                       div_cnt <= div_cnt + DW'(1);
      if (handshake) begin
        edge_cnt <= '0;
        if (CPHA == 0) begin
          spi_mosi <= first_bit(tx_data);
          tx_shift <= shift_out(tx_data);
        end else begin
          spi_mosi <= 1'b0;
          tx_shift <= tx_data;
        end
      end
      if (edge_fire) begin
        edge_cnt <= edge_num;
        spi_sclk <= ~spi_sclk;
      end
      if (shift_now) begin
        spi_mosi <= first_bit(tx_shift);
        tx_shift <= shift_out(tx_shift);
      end
      if (sample_now)
        rx_shift <= (FSB != 0) ? {rx_shift[WIDTH-2:0], spi_miso} : {spi_miso, rx_shift[WIDTH-1:1]};
      if (state == TRAIL && tick)
        spi_mosi <= 1'b0;
    end
  end

  // A word completing while the previous one is still unread overwrites it.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rx_data    <= '0;
      rx_valid   <= 1'b0;
      rx_overrun <= 1'b0;
    end else begin
      rx_overrun <= rx_done && rx_valid && !rx_ready;
      if (rx_done) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end else if (rx_valid && rx_ready) begin
        rx_valid <= 1'b0;
      end
    end
  end

endmodule
